wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 211 +++++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone classic arbiter sharing one slave port.
// Master 0 is the host bridge, master 1 the internal engine. Ownership is
// granted one cycle after a request, held for the whole CYC, and alternates
// round-robin under contention. One dead IDLE cycle always separates owners.
// Optional watchdog: define WB_ARB_TIMEOUT_EN to raise a one-cycle ERR to the
// owner when the slave stalls a strobe for TIMEOUT_CYCLES cycles.
module wb_arbiter2 #(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    // master 0 (host bridge)
    input  logic        m0_CYC,
    input  logic        m0_STB,
    input  logic        m0_WE,
    input  logic [13:0] m0_ADR,
    input  logic [31:0] m0_DAT_MOSI,
    input  logic [3:0]  m0_SEL,
    output logic        m0_ACK,
    output logic        m0_ERR,
    output logic [31:0] m0_DAT_MISO,
    // master 1 (internal engine)
    input  logic        m1_CYC,
    input  logic        m1_STB,
    input  logic        m1_WE,
    input  logic [13:0] m1_ADR,
    input  logic [31:0] m1_DAT_MOSI,
    input  logic [3:0]  m1_SEL,
    output logic        m1_ACK,
    output logic        m1_ERR,
    output logic [31:0] m1_DAT_MISO,
    // shared slave
    output logic        s_CYC,
    output logic        s_STB,
    output logic        s_WE,
    output logic [13:0] s_ADR,
    output logic [31:0] s_DAT_MOSI,
    output logic [3:0]  s_SEL,
    input  logic        s_ACK,
    input  logic [31:0] s_DAT_MISO,
    // registered one-hot grant status
    output logic [1:0]  grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN0  = 2'd1,
        OWN1  = 2'd2,
        ABORT = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_grant;
    logic [1:0]  w_next_grant;
    logic        r_last_owner;       // 0: master 0 was granted last, 1: master 1
    logic        w_next_last_owner;

    logic        w_req0;
    logic        w_req1;
    logic        w_owner_stb;        // strobe of the current owner, 0 when not owning
    logic        w_owner_cyc;        // CYC of the recorded owner (used in ABORT)
    logic        w_timeout;          // watchdog expiry this cycle, ACK takes priority

    assign w_req0 = m0_CYC & m0_STB;
    assign w_req1 = m1_CYC & m1_STB;

    assign w_owner_stb = (r_state == OWN0) ? m0_STB :
                         (r_state == OWN1) ? m1_STB : 1'b0;
    assign w_owner_cyc = r_grant[1] ? m1_CYC : m0_CYC;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] r_count;
    logic [7:0] w_next_count;

    assign w_timeout = (r_count == TIMEOUT_CYCLES) && w_owner_stb && !s_ACK;

    // Stall counter: counts owner strobe cycles without ACK, clears otherwise.
    always_comb begin
        w_next_count = 8'd0;
        if ((r_state == OWN0 || r_state == OWN1) && (w_next_state == r_state) &&
            w_owner_stb && !s_ACK) begin
            w_next_count = r_count + 8'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 8'd0;
        end else begin
            r_count <= w_next_count;
        end
    end
`else
    // Watchdog absent: the parameter has no effect and ABORT is never entered.
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    // Next-state, grant and round-robin pointer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave it unassigned; otherwise synthesis infers a latch.
        w_next_state      = r_state;
        w_next_grant      = r_grant;
        w_next_last_owner = r_last_owner;
        case (r_state)
            IDLE: begin
                if (w_req0 && (!w_req1 || r_last_owner)) begin
                    w_next_state      = OWN0;
                    w_next_grant      = 2'b01;
                    w_next_last_owner = 1'b0;
                end else if (w_req1) begin
                    w_next_state      = OWN1;
                    w_next_grant      = 2'b10;
                    w_next_last_owner = 1'b1;
                end
            end
            OWN0: begin
                if (!m0_CYC) begin
                    w_next_state = IDLE;
                    w_next_grant = 2'b00;
                end else if (w_timeout) begin
                    w_next_state = ABORT;
                end
            end
            OWN1: begin
                if (!m1_CYC) begin
                    w_next_state = IDLE;
                    w_next_grant = 2'b00;
                end else if (w_timeout) begin
                    w_next_state = ABORT;
                end
            end
            ABORT: begin
                // Grant keeps naming the aborted owner until it releases CYC.
                if (!w_owner_cyc) begin
                    w_next_state = IDLE;
                    w_next_grant = 2'b00;
                end
            end
            default: begin
                w_next_state = IDLE;
                w_next_grant = 2'b00;
            end
        endcase
    end

    // State, grant and round-robin registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples the
        // pre-edge values; blocking ones would create ordering races.
        if (rst) begin
            r_state      <= IDLE;
            r_grant      <= 2'b00;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_next_state;
            r_grant      <= w_next_grant;
            r_last_owner <= w_next_last_owner;
        end
    end

    // Request/response steering: owner is wired through, everything else is 0.
    always_comb begin
        s_CYC       = 1'b0;
        s_STB       = 1'b0;
        s_WE        = 1'b0;
        s_ADR       = 14'd0;
        s_DAT_MOSI  = 32'd0;
        s_SEL       = 4'd0;
        m0_ACK      = 1'b0;
        m0_ERR      = 1'b0;
        m0_DAT_MISO = 32'd0;
        m1_ACK      = 1'b0;
        m1_ERR      = 1'b0;
        m1_DAT_MISO = 32'd0;
        case (r_state)
            OWN0: begin
                s_CYC       = m0_CYC;
                s_STB       = m0_STB;
                s_WE        = m0_WE;
                s_ADR       = m0_ADR;
                s_DAT_MOSI  = m0_DAT_MOSI;
                s_SEL       = m0_SEL;
                m0_ACK      = s_ACK;
                m0_ERR      = w_timeout;
                m0_DAT_MISO = s_DAT_MISO;
            end
            OWN1: begin
                s_CYC       = m1_CYC;
                s_STB       = m1_STB;
                s_WE        = m1_WE;
                s_ADR       = m1_ADR;
                s_DAT_MOSI  = m1_DAT_MOSI;
                s_SEL       = m1_SEL;
                m1_ACK      = s_ACK;
                m1_ERR      = w_timeout;
                m1_DAT_MISO = s_DAT_MISO;
            end
            default: begin
                // IDLE and ABORT: slave port quiet, stray ACKs dropped.
            end
        endcase
    end

    assign grant = r_grant;

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed testbench for wb_arbiter2 (TIMEOUT_CYCLES = 4). Expectations for
// the watchdog scenario follow whether WB_ARB_TIMEOUT_EN is defined.
module tb_wb_arbiter2;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_CYC, m0_STB, m0_WE;
    logic [13:0] m0_ADR;
    logic [31:0] m0_DAT_MOSI;
    logic [3:0]  m0_SEL;
    logic        m0_ACK, m0_ERR;
    logic [31:0] m0_DAT_MISO;
    logic        m1_CYC, m1_STB, m1_WE;
    logic [13:0] m1_ADR;
    logic [31:0] m1_DAT_MOSI;
    logic [3:0]  m1_SEL;
    logic        m1_ACK, m1_ERR;
    logic [31:0] m1_DAT_MISO;
    logic        s_CYC, s_STB, s_WE;
    logic [13:0] s_ADR;
    logic [31:0] s_DAT_MOSI;
    logic [3:0]  s_SEL;
    logic        s_ACK;
    logic [31:0] s_DAT_MISO;
    logic [1:0]  grant;

    int n_checks = 0;
    int n_pass   = 0;

    wb_arbiter2 #(.TIMEOUT_CYCLES(8'd4)) dut (
        .clk(clk), .rst(rst),
        .m0_CYC(m0_CYC), .m0_STB(m0_STB), .m0_WE(m0_WE), .m0_ADR(m0_ADR),
        .m0_DAT_MOSI(m0_DAT_MOSI), .m0_SEL(m0_SEL),
        .m0_ACK(m0_ACK), .m0_ERR(m0_ERR), .m0_DAT_MISO(m0_DAT_MISO),
        .m1_CYC(m1_CYC), .m1_STB(m1_STB), .m1_WE(m1_WE), .m1_ADR(m1_ADR),
        .m1_DAT_MOSI(m1_DAT_MOSI), .m1_SEL(m1_SEL),
        .m1_ACK(m1_ACK), .m1_ERR(m1_ERR), .m1_DAT_MISO(m1_DAT_MISO),
        .s_CYC(s_CYC), .s_STB(s_STB), .s_WE(s_WE), .s_ADR(s_ADR),
        .s_DAT_MOSI(s_DAT_MOSI), .s_SEL(s_SEL),
        .s_ACK(s_ACK), .s_DAT_MISO(s_DAT_MISO),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling (well before next edge).
    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        m0_CYC = 0; m0_STB = 0; m0_WE = 0; m0_ADR = '0; m0_DAT_MOSI = '0; m0_SEL = '0;
        m1_CYC = 0; m1_STB = 0; m1_WE = 0; m1_ADR = '0; m1_DAT_MOSI = '0; m1_SEL = '0;
        s_ACK = 0; s_DAT_MISO = '0;

        // Reset state, with a request already presented.
        step();
        m0_CYC = 1; m0_STB = 1;
        step();
        settle();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_stb", 32'(s_STB), 32'd0);
        check("rst_m0_ack", 32'(m0_ACK), 32'd0);
        m0_CYC = 0; m0_STB = 0;
        step();
        rst = 1'b0;

        // Single m0 read, ACK two cycles after grant.
        m0_CYC = 1; m0_STB = 1; m0_WE = 0; m0_ADR = 14'h0010; m0_SEL = 4'hF;
        settle();
        check("rd_idle_stb", 32'(s_STB), 32'd0);
        step();
        settle();
        check("rd_grant", 32'(grant), 32'h1);
        check("rd_s_stb", 32'(s_STB), 32'd1);
        check("rd_s_adr", 32'(s_ADR), 32'h0010);
        check("rd_no_ack", 32'(m0_ACK), 32'd0);
        step();
        s_ACK = 1; s_DAT_MISO = 32'hDEADBEEF;
        settle();
        check("rd_ack", 32'(m0_ACK), 32'd1);
        check("rd_data", m0_DAT_MISO, 32'hDEADBEEF);
        check("rd_m1_ack", 32'(m1_ACK), 32'd0);
        step();
        s_ACK = 0; s_DAT_MISO = '0; m0_CYC = 0; m0_STB = 0;
        settle();
        check("rd_ack_gone", 32'(m0_ACK), 32'd0);
        check("rd_s_cyc_low", 32'(s_CYC), 32'd0);
        step();
        settle();
        check("rd_grant_idle", 32'(grant), 32'd0);

        // Spurious slave ACK while idle.
        s_ACK = 1; s_DAT_MISO = 32'h12345678;
        settle();
        check("spur_m0_ack", 32'(m0_ACK), 32'd0);
        check("spur_m1_ack", 32'(m1_ACK), 32'd0);
        check("spur_m0_dat", m0_DAT_MISO, 32'd0);
        step();
        s_ACK = 0; s_DAT_MISO = '0;
        settle();
        check("spur_idle", 32'(grant), 32'd0);

        // Reset during m0 ownership with strobe pending.
        m0_CYC = 1; m0_STB = 1; m0_ADR = 14'h0020;
        step();
        settle();
        check("rstx_owned", 32'(grant), 32'h1);
        rst = 1'b1;
        step();
        s_ACK = 1; s_DAT_MISO = 32'hCAFEF00D;
        settle();
        check("rstx_grant", 32'(grant), 32'd0);
        check("rstx_s_stb", 32'(s_STB), 32'd0);
        check("rstx_s_adr", 32'(s_ADR), 32'd0);
        check("rstx_m0_ack", 32'(m0_ACK), 32'd0);
        check("rstx_m0_err", 32'(m0_ERR), 32'd0);
        check("rstx_m0_dat", m0_DAT_MISO, 32'd0);

        // Contention after reset: m0 first, m1 after a dead cycle, then m0.
        s_ACK = 0; s_DAT_MISO = '0; rst = 1'b0;
        m0_ADR = 14'h0100;
        m1_CYC = 1; m1_STB = 1; m1_WE = 1; m1_ADR = 14'h0200; m1_SEL = 4'h3;
        m1_DAT_MOSI = 32'hA5A5A5A5;
        step();
        settle();
        check("ct1_grant", 32'(grant), 32'h1);
        check("ct1_s_adr", 32'(s_ADR), 32'h0100);
        // Owner drops CYC in the ACK cycle: ACK still delivered.
        s_ACK = 1; s_DAT_MISO = 32'h00000011; m0_CYC = 0; m0_STB = 0;
        settle();
        check("ct1_ack_drop", 32'(m0_ACK), 32'd1);
        check("ct1_m1_noack", 32'(m1_ACK), 32'd0);
        step();
        s_ACK = 0;
        settle();
        check("ct_dead_cycle", 32'(grant), 32'd0);
        step();
        settle();
        check("ct2_grant", 32'(grant), 32'h2);
        check("ct2_s_adr", 32'(s_ADR), 32'h0200);
        check("ct2_s_dat", s_DAT_MOSI, 32'hA5A5A5A5);
        check("ct2_s_we", 32'(s_WE), 32'd1);
        m1_CYC = 0; m1_STB = 0;
        step();
        m0_CYC = 1; m0_STB = 1;
        m1_CYC = 1; m1_STB = 1;
        settle();
        check("ct3_idle", 32'(grant), 32'd0);
        step();
        settle();
        check("ct3_grant", 32'(grant), 32'h1);
        m0_CYC = 0; m0_STB = 0; m1_CYC = 0; m1_STB = 0;
        step();
        step();

        // m1 block transfer of 4 beats while m0 waits.
        m1_CYC = 1; m1_STB = 1; m1_WE = 0; m1_ADR = 14'h0300;
        step();
        m0_CYC = 1; m0_STB = 1;
        for (int i = 0; i < 4; i++) begin
            s_ACK = 1; s_DAT_MISO = 32'h100 + 32'(i);
            settle();
            check("blk_grant", 32'(grant), 32'h2);
            check("blk_m1_data", m1_DAT_MISO, 32'h100 + 32'(i));
            check("blk_m0_ack", 32'(m0_ACK), 32'd0);
            step();
        end
        s_ACK = 0; s_DAT_MISO = '0; m1_CYC = 0; m1_STB = 0;
        settle();
        check("blk_release", 32'(grant), 32'h2);
        check("blk_rel_m0_ack", 32'(m0_ACK), 32'd0);
        step();
        settle();
        check("blk_dead", 32'(grant), 32'd0);
        step();
        settle();
        check("blk_m0_grant", 32'(grant), 32'h1);
        m0_CYC = 0; m0_STB = 0;
        step();
        step();

        // m1 write that the slave never acknowledges.
        m1_CYC = 1; m1_STB = 1; m1_WE = 1; m1_ADR = 14'h0400;
        step();
        for (int i = 1; i <= 4; i++) begin
            settle();
            check("wd_no_err", 32'(m1_ERR), 32'd0);
            check("wd_stb", 32'(s_STB), 32'd1);
            step();
        end
        settle();
`ifdef WB_ARB_TIMEOUT_EN
        check("wd_err5", 32'(m1_ERR), 32'd1);
`else
        check("wd_err5", 32'(m1_ERR), 32'd0);
`endif
        check("wd_stb5", 32'(s_STB), 32'd1);
        check("wd_m0_err", 32'(m0_ERR), 32'd0);
        step();
        settle();
`ifdef WB_ARB_TIMEOUT_EN
        check("wd_abort_stb", 32'(s_STB), 32'd0);
`else
        check("wd_abort_stb", 32'(s_STB), 32'd1);
`endif
        check("wd_after_err", 32'(m1_ERR), 32'd0);
        check("wd_grant_held", 32'(grant), 32'h2);
        step();
        m1_CYC = 0; m1_STB = 0;
        settle();
        check("wd_drop_grant", 32'(grant), 32'h2);
        step();
        settle();
        check("wd_idle", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
